// File: rtl/census_pkg.sv
// Shared constants and FSM encoding for the census pixel source.
package census_pkg;

  localparam int unsigned IMAGE_ROW_DEF = 200;
  localparam int unsigned IMAGE_COL_DEF = 400;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned COORD_W       = 10;
  localparam int unsigned FCNT_W        = 5;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/pixel_coord_counter.sv
// Raster-order row/col counter with last-pixel flag; wraps to (0,0) after the last pixel.
module pixel_coord_counter
  import census_pkg::*;
#(
  parameter int unsigned ROWS = IMAGE_ROW_DEF,
  parameter int unsigned COLS = IMAGE_COL_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               adv,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last
);

  logic [COORD_W-1:0] row_d, row_q;
  logic [COORD_W-1:0] col_d, col_q;
  logic               col_end, row_end;

  // Next coordinate: clear wins over advance; col wraps into row, row wraps at frame end
  always_comb begin
    col_end = (col_q == COORD_W'(COLS - 1));
    row_end = (row_q == COORD_W'(ROWS - 1));
    row_d   = row_q;
    col_d   = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Coordinate registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign last = col_end && row_end;

endmodule

// File: rtl/census_pixel_source.sv
// Streams image RAM pixels in raster order to the census core, one every PIXEL_GAP cycles.
// Build option: define LOOP_FRAMES_EN to stream frames back to back until reset.
module census_pixel_source
  import census_pkg::*;
#(
  parameter int unsigned IMAGE_ROW = IMAGE_ROW_DEF,
  parameter int unsigned IMAGE_COL = IMAGE_COL_DEF,
  parameter int unsigned PIXEL_GAP = 13,
  parameter int unsigned ADDR_W    = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               hold,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic               en,
  output logic [PIX_W-1:0]   grey_out,
  output logic [COORD_W-1:0] row_out,
  output logic [COORD_W-1:0] col_out,
  output logic               frame_done,
  output logic [FCNT_W-1:0]  frame_cnt,
  output logic               busy
);

  localparam int unsigned PhW = $clog2(PIXEL_GAP);

  state_e               state_d, state_q;
  logic [PhW-1:0]       ph_d, ph_q;
  logic                 en_d, en_q;
  logic                 frame_done_d, frame_done_q;
  logic [PIX_W-1:0]     grey_d, grey_q;
  logic [COORD_W-1:0]   row_d, row_q;
  logic [COORD_W-1:0]   col_d, col_q;
  logic [FCNT_W-1:0]    fcnt_d, fcnt_q;

  logic                 cnt_clr, cnt_adv, cur_last;
  logic [COORD_W-1:0]   cur_row, cur_col;

  pixel_coord_counter #(
    .ROWS (IMAGE_ROW),
    .COLS (IMAGE_COL)
  ) u_coord (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .adv  (cnt_adv),
    .row  (cur_row),
    .col  (cur_col),
    .last (cur_last)
  );

  // FSM, phase sequencing and output-register next state
  always_comb begin
    state_d      = state_q;
    ph_d         = ph_q;
    en_d         = 1'b0;
    frame_done_d = 1'b0;
    grey_d       = grey_q;
    row_d        = row_q;
    col_d        = col_q;
    fcnt_d       = fcnt_q;
    mem_rd_en    = 1'b0;
    cnt_clr      = 1'b0;
    cnt_adv      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          ph_d    = '0;
          cnt_clr = 1'b1;
        end
      end
      StRun: begin
        if (ph_q == '0) begin
          // hold only gates the read issue; once issued the pixel completes
          if (!hold) begin
            mem_rd_en = 1'b1;
            ph_d      = PhW'(1);
          end
        end else begin
          ph_d = (ph_q == PhW'(PIXEL_GAP - 1)) ? '0 : ph_q + 1'b1;
          if (ph_q == PhW'(1)) begin
            en_d    = 1'b1;
            grey_d  = mem_rdata;
            row_d   = cur_row;
            col_d   = cur_col;
            cnt_adv = 1'b1;
            if (cur_last) begin
              frame_done_d = 1'b1;
              fcnt_d       = fcnt_q + 1'b1;
            end
          end
        end
`ifdef LOOP_FRAMES_EN
        // coordinate counter has already wrapped to (0,0); keep the same cadence
`else
        if (frame_done_q) state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ph_q         <= '0;
      en_q         <= 1'b0;
      frame_done_q <= 1'b0;
      grey_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      fcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      en_q         <= en_d;
      frame_done_q <= frame_done_d;
      grey_q       <= grey_d;
      row_q        <= row_d;
      col_q        <= col_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign mem_addr   = ADDR_W'(cur_row) * ADDR_W'(IMAGE_COL) + ADDR_W'(cur_col);
  assign en         = en_q;
  assign grey_out   = grey_q;
  assign row_out    = row_q;
  assign col_out    = col_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = fcnt_q;
  assign busy       = (state_q == StRun);

endmodule

// File: tb/tb_census_pixel_source.sv
// Directed, table-driven bench for census_pixel_source on a 2x3 image, PIXEL_GAP=4.
module tb_census_pixel_source;

  logic        clk = 1'b0;
  logic        rst, start, hold;
  logic        mem_rd_en;
  logic [16:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        en, frame_done, busy;
  logic [7:0]  grey_out;
  logic [9:0]  row_out, col_out;
  logic [4:0]  frame_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int dcyc;
    int row;
    int col;
    int grey;
    int fd;
    int fcnt;
  } exp_t;

  typedef struct {
    int cyc;
    int row;
    int col;
    int grey;
    int fd;
    int fcnt;
  } ev_t;

  exp_t tbl [6];
  ev_t  ev_q [$];
  logic [7:0] ram [8];

  census_pixel_source #(
    .IMAGE_ROW (2),
    .IMAGE_COL (3),
    .PIXEL_GAP (4),
    .ADDR_W    (17)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .hold       (hold),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .en         (en),
    .grey_out   (grey_out),
    .row_out    (row_out),
    .col_out    (col_out),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency image RAM
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr[2:0]];

  // Capture every pixel strobe away from the active edge
  always @(negedge clk) begin
    if (en) begin
      ev_t e;
      e.cyc  = cyc;
      e.row  = int'(row_out);
      e.col  = int'(col_out);
      e.grey = int'(grey_out);
      e.fd   = int'(frame_done);
      e.fcnt = int'(frame_cnt);
      ev_q.push_back(e);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    wait_cycles(5);
    rst = 1'b0;
    ev_q.delete();
  endtask

  // start is high for exactly the cycle whose number is returned
  task automatic start_pulse(output int s);
    s     = cyc;
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  // Waits for the frame end, then compares captured pixels against the table.
  // Pixels from index hold_at onward are expected hold_len cycles late.
  task automatic check_frame(input string tag, input int s, input int hold_at, input int hold_len);
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk({tag, " frame_done seen"}, int'(seen), 1);
    chk({tag, " busy at frame_done"}, int'(busy), 1);
    @(negedge clk);
`ifndef LOOP_FRAMES_EN
    chk({tag, " busy after frame_done"}, int'(busy), 0);
`endif
    chk({tag, " pixel count"}, ev_q.size(), 6);
    for (int i = 0; i < 6 && i < ev_q.size(); i++) begin
      int d;
      d = tbl[i].dcyc + ((i >= hold_at) ? hold_len : 0);
      chk($sformatf("%s px%0d en cycle", tag, i), ev_q[i].cyc - s, d);
      chk($sformatf("%s px%0d row", tag, i), ev_q[i].row, tbl[i].row);
      chk($sformatf("%s px%0d col", tag, i), ev_q[i].col, tbl[i].col);
      chk($sformatf("%s px%0d grey", tag, i), ev_q[i].grey, tbl[i].grey);
      chk($sformatf("%s px%0d frame_done", tag, i), ev_q[i].fd, tbl[i].fd);
      chk($sformatf("%s px%0d frame_cnt", tag, i), ev_q[i].fcnt, tbl[i].fcnt);
    end
  endtask

  initial begin
    int s;
    for (int i = 0; i < 8; i++) ram[i] = 8'(8'h10 + i);

    //          dcyc row col grey  fd fcnt
    tbl[0] = '{ 3,  0,  0,  'h10, 0, 0};
    tbl[1] = '{ 7,  0,  1,  'h11, 0, 0};
    tbl[2] = '{11,  0,  2,  'h12, 0, 0};
    tbl[3] = '{15,  1,  0,  'h13, 0, 0};
    tbl[4] = '{19,  1,  1,  'h14, 0, 0};
    tbl[5] = '{23,  1,  2,  'h15, 1, 1};

    rst   = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    wait_cycles(5);
    chk("reset en", int'(en), 0);
    chk("reset grey_out", int'(grey_out), 0);
    chk("reset row_out", int'(row_out), 0);
    chk("reset col_out", int'(col_out), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset frame_cnt", int'(frame_cnt), 0);
    chk("reset busy", int'(busy), 0);
    rst = 1'b0;
    wait_cycles(2);
    chk("idle busy", int'(busy), 0);

    // Tests 1/2: plain frame, cadence and frame end
    ev_q.delete();
    start_pulse(s);
    chk("t1 busy after start", int'(busy), 1);
    check_frame("t1", s, 99, 0);

    // Test 3: hold for 5 cycles at the ph==0 before pixel (0,1)
    do_reset();
    start_pulse(s);         // now in cycle s+1
    wait_cycles(4);         // cycle s+5: ph==0 for pixel (0,1)
    hold = 1'b1;
    wait_cycles(5);
    hold = 1'b0;
    check_frame("t3", s, 1, 5);

    // Test 4: reset the cycle after the (1,0) strobe, then restart
    do_reset();
    start_pulse(s);
    wait_cycles(15);        // cycle s+16
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    chk("t4 en after rst", int'(en), 0);
    chk("t4 grey after rst", int'(grey_out), 0);
    chk("t4 row after rst", int'(row_out), 0);
    chk("t4 col after rst", int'(col_out), 0);
    chk("t4 frame_cnt after rst", int'(frame_cnt), 0);
    chk("t4 busy after rst", int'(busy), 0);
    chk("t4 pixels before rst", ev_q.size(), 4);
    wait_cycles(8);
    chk("t4 no pixels while idle", ev_q.size(), 4);
    ev_q.delete();
    start_pulse(s);
    check_frame("t4 restart", s, 99, 0);

    // start together with rst: rst wins
    rst   = 1'b1;
    start = 1'b1;
    wait_cycles(1);
    rst   = 1'b0;
    start = 1'b0;
    wait_cycles(1);
    chk("rst beats start busy", int'(busy), 0);

    // Test 6: start pulsed mid-frame is ignored
    do_reset();
    start_pulse(s);
    wait_cycles(8);         // cycle s+9
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(3);         // cycle s+13, a ph==0 cycle
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    check_frame("t6", s, 99, 0);

`ifdef LOOP_FRAMES_EN
    // Test 5: 33 back-to-back frames, frame_cnt wraps 31->0
    begin
      int nd   = 0;
      int f31  = -1;
      int f32  = -1;
      int errs = 0;
      do_reset();
      start_pulse(s);
      for (int i = 0; i < 1200 && nd < 33; i++) begin
        @(negedge clk);
        if (frame_done) begin
          nd++;
          if (nd == 31) f31 = int'(frame_cnt);
          if (nd == 32) f32 = int'(frame_cnt);
        end
      end
      chk("t5 frames completed", nd, 33);
      chk("t5 frame_cnt at 31st", f31, 31);
      chk("t5 frame_cnt wrap at 32nd", f32, 0);
      chk("t5 busy stays high", int'(busy), 1);
      chk("t5 pixel count", ev_q.size(), 198);
      for (int i = 0; i < ev_q.size(); i++) begin
        int k;
        k = i % 6;
        if (ev_q[i].cyc - s != 3 + 4 * i || ev_q[i].row != tbl[k].row ||
            ev_q[i].col != tbl[k].col || ev_q[i].grey != tbl[k].grey ||
            ev_q[i].fd != tbl[k].fd) errs++;
      end
      chk("t5 loop cadence/sequence errors", errs, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
